// File: rtl/bitwise_logic_unit_pkg.sv
// Shared encodings for the bitwise logic unit:
// op select values, FSM states and a sizing helper.
package bitwise_logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOT  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitwise_logic_unit_lane_op.sv
// One LANE-wide slice of the bitwise datapath:
// a pure op-select mux over the eight operations.
module bitwise_lane_op
  import bitwise_logic_unit_pkg::*;
#(
  parameter int LANE = 5
) (
  input  op_e             op,
  input  logic [LANE-1:0] a,
  input  logic [LANE-1:0] b,
  output logic [LANE-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_PASS: y = a;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic unit: latches an op, walks the
// operands LANE bits per cycle, then holds result and flags.
module bitwise_logic_unit
  import bitwise_logic_unit_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int LANE  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             zero,
  output logic             parity
);

  localparam int NLANE = WIDTH / LANE;
  localparam int IW    = lane_idx_w(NLANE);
  localparam logic [IW-1:0] LAST = IW'(NLANE - 1);

  if (LANE < 1 || WIDTH % LANE != 0) begin : g_bad_lane
    $error("WIDTH must be a positive multiple of LANE");
  end

  state_e           state;
  logic [IW-1:0]    idx;
  op_e              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] s_q;
  logic             rdy_q;
  logic             vld_q;
  logic             zero_q;
  logic             par_q;
  logic [LANE-1:0]  lane_y;
  int unsigned      base;

  assign base = 32'(idx) * 32'(LANE);

  bitwise_lane_op #(
    .LANE (LANE)
  ) u_lane (
    .op (op_q),
    .a  (a_q[base +: LANE]),
    .b  (b_q[base +: LANE]),
    .y  (lane_y)
  );

  // Full word with the current lane merged in; flags come from this
  always_comb begin
    res_next = res_q;
    res_next[base +: LANE] = lane_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      op_q   <= OP_AND;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      s_q    <= '0;
      rdy_q  <= 1'b1;
      vld_q  <= 1'b0;
      zero_q <= 1'b0;
      par_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q  <= op_e'(op);
            a_q   <= i0;
            b_q   <= i1;
            idx   <= '0;
            rdy_q <= 1'b0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          res_q <= res_next;
          if (idx == LAST) begin
            idx    <= '0;
            s_q    <= res_next;
            zero_q <= ~|res_next;
            par_q  <= ^res_next;
            vld_q  <= 1'b1;
            state  <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          rdy_q <= 1'b1;
          vld_q <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign s         = s_q;
  assign zero      = zero_q;
  assign parity    = par_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Randomised bench for bitwise_logic_unit at three geometries
// (20/5, 8/8, 32/4) against a whole-word reference model.
module tb_bitwise_logic_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  wire  [2:0]  ir;
  wire  [2:0]  ov;
  wire  [2:0]  zf;
  wire  [2:0]  pf;
  wire  [19:0] s0;
  wire  [7:0]  s1;
  wire  [31:0] s2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bitwise_logic_unit #(.WIDTH(20), .LANE(5)) u20 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .op(op), .i0(a[19:0]), .i1(b[19:0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .s(s0), .zero(zf[0]), .parity(pf[0])
  );

  bitwise_logic_unit #(.WIDTH(8), .LANE(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .op(op), .i0(a[7:0]), .i1(b[7:0]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .s(s1), .zero(zf[1]), .parity(pf[1])
  );

  bitwise_logic_unit #(.WIDTH(32), .LANE(4)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .op(op), .i0(a), .i1(b), .out_valid(ov[2]),
    .out_ready(ordy[2]), .s(s2), .zero(zf[2]), .parity(pf[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic int w_of(input int k);
    case (k)
      0:       return 20;
      1:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int nl_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] s_of(input int k);
    case (k)
      0:       return {12'd0, s0};
      1:       return {24'd0, s1};
      default: return s2;
    endcase
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y,
                                         input int w);
    logic [31:0] r;
    logic [31:0] m;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case (o)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = x ^ y;
      3'd3:    r = ~(x & y);
      3'd4:    r = ~(x | y);
      3'd5:    r = ~(x ^ y);
      3'd6:    r = ~x;
      default: r = x;
    endcase
    return r & m;
  endfunction

  task automatic run_op(input int k, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input bit scr, input int hold,
                        input string tag);
    logic [31:0] e;
    int lat;
    e = ref_op(o, x, y, w_of(k));
    @(negedge clk);
    chk({tag, ".rdy_idle"}, {31'd0, ir[k]}, 32'd1);
    op = o;
    a = x;
    b = y;
    iv[k] = 1'b1;
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    chk({tag, ".rdy_busy"}, {31'd0, ir[k]}, 32'd0);
    lat = 0;
    while (lat < 50) begin
      if (scr) begin
        a  = $urandom;
        b  = $urandom;
        op = 3'($urandom_range(7));
      end
      @(posedge clk);
      lat++;
      #1;
      if (ov[k]) break;
    end
    chk({tag, ".lat"}, lat, nl_of(k));
    chk({tag, ".s"}, s_of(k), e);
    chk({tag, ".zero"}, {31'd0, zf[k]}, {31'd0, e == 32'd0});
    chk({tag, ".par"}, {31'd0, pf[k]}, {31'd0, ^e});
    for (int h = 0; h < hold; h++) begin
      iv[k] = 1'b1;
      op = 3'($urandom_range(7));
      a  = $urandom;
      b  = $urandom;
      @(posedge clk);
      #1;
      chk({tag, ".hold_v"}, {31'd0, ov[k]}, 32'd1);
      chk({tag, ".hold_s"}, s_of(k), e);
      chk({tag, ".hold_rdy"}, {31'd0, ir[k]}, 32'd0);
    end
    iv[k] = 1'b0;
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
    chk({tag, ".ack_v"}, {31'd0, ov[k]}, 32'd0);
    chk({tag, ".ack_rdy"}, {31'd0, ir[k]}, 32'd1);
  endtask

  initial begin
    rst  = 1'b1;
    iv   = '0;
    ordy = '0;
    op   = '0;
    a    = '0;
    b    = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst.rdy", {31'd0, ir[k]}, 32'd1);
      chk("rst.vld", {31'd0, ov[k]}, 32'd0);
      chk("rst.s", s_of(k), 32'd0);
      chk("rst.zero", {31'd0, zf[k]}, 32'd0);
      chk("rst.par", {31'd0, pf[k]}, 32'd0);
    end
    rst = 1'b0;

    run_op(0, 3'd2, 32'h0005F, 32'h00000, 1'b0, 0, "xor5f");
    run_op(0, 3'd2, 32'hC0003, 32'hC0003, 1'b0, 0, "xorc3");
    run_op(0, 3'd2, 32'hFFFFF, 32'hFFFFF, 1'b0, 0, "xorff");
    run_op(0, 3'd2, 32'hFFFFF, 32'h00000, 1'b0, 0, "xorf0");
    run_op(0, 3'd6, 32'h00001, 32'h12345, 1'b0, 0, "not1");
    run_op(0, 3'd0, 32'hA5A5A, 32'h0FF0F, 1'b0, 10, "hold");
    run_op(0, 3'd1, 32'h12345, 32'h54321, 1'b1, 0, "scram");

    // abort in the second busy cycle, with a competing in_valid
    @(negedge clk);
    op = 3'd2;
    a  = 32'h13579;
    b  = 32'h2468A;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.vld", {31'd0, ov[0]}, 32'd0);
    chk("abort.rdy", {31'd0, ir[0]}, 32'd1);
    chk("abort.s", s_of(0), 32'd0);
    chk("abort.zero", {31'd0, zf[0]}, 32'd0);
    rst = 1'b0;
    iv[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort.noacc", {31'd0, ov[0]}, 32'd0);
    chk("abort.idle", {31'd0, ir[0]}, 32'd1);
    run_op(0, 3'd5, 32'h0F0F0, 32'h00FF0, 1'b0, 0, "fresh");

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 8; n++)
        run_op(k, 3'(n), $urandom, $urandom, 1'b1, 0, "allop");
      for (int n = 0; n < 30; n++)
        run_op(k, 3'($urandom_range(7)), $urandom, $urandom,
               1'($urandom_range(1)), 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
